audio_sample_exchange: RTL

Frame-rate sample exchange between the codec serializer/deserializer and the DSP datapath, clocked by the sample clock. It generalises the single-register sampling buffer to CH channels of DATA_W bits, with a DEPTH-frame playback FIFO gated by a prefill state machine and a DEPTH-frame capture FIFO with valid/ready handshake. Sticky underrun/overrun flags report faults. It sits between the codec I/O buffer (parallel frame side) and the audio processing pipeline.

---
 rtl/audio_sample_exchange.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/audio_sample_exchange.sv
// audio_sample_exchange: frame-rate exchange between the codec SerDes and the DSP datapath.
// Latency: a capture frame shows on cap_data_o one edge after it is sampled. A playback frame reaches dac_frame_o two or more edges after its push.
// Backpressure: play_ready_o drops when the playback FIFO is full. A full capture FIFO that is not popped drops the new frame and sets overrun_o.
//
// Ports:
//   clk_sample, rst_ni         frame clock, async active-low reset
//   en_i                       block enable; low flushes both FIFOs and forces IDLE
//   play_valid_i/_ready_o/_data_i   playback push side (DSP -> FIFO)
//   dac_frame_o                registered frame to the DAC serializer
//   adc_frame_i                ADC frame, captured every edge in PRIME/RUN
//   cap_valid_o/_ready_i/_data_o    capture pop side, first-word fall-through
//   play_fill_o                playback occupancy
//   underrun_o, overrun_o, clear_i  sticky fault flags and their clear
// Build option: define AUDIO_XCHG_HOLD_LAST_EN so that dac_frame_o holds the last popped
// frame in PRIME and on an underrun edge. When it is undefined, those cases output zero.

module audio_sample_exchange #(
  parameter int DATA_W  = 24,
  parameter int CH      = 2,
  parameter int DEPTH   = 4,
  parameter int PREFILL = 2
) (
  input  logic                   clk_sample,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   play_valid_i,
  output logic                   play_ready_o,
  input  logic [CH*DATA_W-1:0]   play_data_i,
  output logic [CH*DATA_W-1:0]   dac_frame_o,
  input  logic [CH*DATA_W-1:0]   adc_frame_i,
  output logic                   cap_valid_o,
  input  logic                   cap_ready_i,
  output logic [CH*DATA_W-1:0]   cap_data_o,
  output logic [$clog2(DEPTH):0] play_fill_o,
  output logic                   underrun_o,
  output logic                   overrun_o,
  input  logic                   clear_i
);

  localparam int FW = CH * DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;

  state_e        state_q;
  logic [FW-1:0] play_mem_q [DEPTH];
  logic [FW-1:0] cap_mem_q  [DEPTH];
  logic [PW-1:0] pwr_q, prd_q, cwr_q, crd_q;
  logic [CW-1:0] pcnt_q, pcnt_d, ccnt_q, ccnt_d;
  logic [FW-1:0] dac_q;
  logic          und_q, ovr_q;

  logic          play_push, play_pop, cap_push, cap_pop, cap_full;
  logic          underrun_evt, overrun_evt;
  logic [FW-1:0] idle_frame;

`ifdef AUDIO_XCHG_HOLD_LAST_EN
  // dac_q already carries the last popped frame. It is zero after reset or IDLE,
  // because nothing has been popped since then.
  assign idle_frame = dac_q;
`else
  assign idle_frame = '0;
`endif

  always_comb begin
    // Ready is built from registered state only, so a pop on a full edge cannot admit a push.
    play_ready_o = (state_q != IDLE) && (pcnt_q < DEPTH_C);
    play_push    = en_i && play_valid_i && play_ready_o;
    play_pop     = en_i && (state_q == RUN) && (pcnt_q != '0);
    underrun_evt = en_i && (state_q == RUN) && (pcnt_q == '0);

    cap_valid_o  = (ccnt_q != '0);
    cap_pop      = en_i && cap_valid_o && cap_ready_i;
    cap_full     = (ccnt_q == DEPTH_C);
    // When the FIFO is full, a same-edge pop frees the slot that the new frame takes.
    cap_push     = en_i && (state_q != IDLE) && (!cap_full || cap_pop);
    overrun_evt  = en_i && (state_q != IDLE) && cap_full && !cap_pop;
    cap_data_o   = cap_valid_o ? cap_mem_q[crd_q] : '0;

    pcnt_d = pcnt_q;
    if (play_push && !play_pop)      pcnt_d = pcnt_q + CNT_ONE;
    else if (play_pop && !play_push) pcnt_d = pcnt_q - CNT_ONE;

    ccnt_d = ccnt_q;
    if (cap_push && !cap_pop)        ccnt_d = ccnt_q + CNT_ONE;
    else if (cap_pop && !cap_push)   ccnt_d = ccnt_q - CNT_ONE;
  end

  // Frame storage has no reset. Its contents are only visible through valid counts.
  always_ff @(posedge clk_sample) begin
    if (play_push) play_mem_q[pwr_q] <= play_data_i;
    if (cap_push)  cap_mem_q[cwr_q]  <= adc_frame_i;
  end

  always_ff @(posedge clk_sample or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pwr_q   <= '0;
      prd_q   <= '0;
      cwr_q   <= '0;
      crd_q   <= '0;
      pcnt_q  <= '0;
      ccnt_q  <= '0;
      dac_q   <= '0;
      und_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // A new fault wins over a same-edge clear.
      und_q <= underrun_evt || (und_q && !clear_i);
      ovr_q <= overrun_evt  || (ovr_q && !clear_i);
      if (!en_i) begin
        state_q <= IDLE;
        pwr_q   <= '0;
        prd_q   <= '0;
        cwr_q   <= '0;
        crd_q   <= '0;
        pcnt_q  <= '0;
        ccnt_q  <= '0;
        dac_q   <= '0;
      end else begin
        pcnt_q <= pcnt_d;
        ccnt_q <= ccnt_d;
        if (play_push) pwr_q <= pwr_q + PTR_ONE;
        if (play_pop)  prd_q <= prd_q + PTR_ONE;
        if (cap_push)  cwr_q <= cwr_q + PTR_ONE;
        if (cap_pop)   crd_q <= crd_q + PTR_ONE;
        case (state_q)
          IDLE: begin
            state_q <= PRIME;
            dac_q   <= '0;
          end
          PRIME: begin
            dac_q <= idle_frame;
            // The transition edge itself never pops.
            if (pcnt_q >= PREFILL_C) state_q <= RUN;
          end
          RUN: begin
            if (play_pop) begin
              dac_q <= play_mem_q[prd_q];
            end else begin
              dac_q   <= idle_frame;
              state_q <= PRIME;
            end
          end
          default: begin
            state_q <= IDLE;
            dac_q   <= '0;
          end
        endcase
      end
    end
  end

  assign dac_frame_o = dac_q;
  assign play_fill_o = pcnt_q;
  assign underrun_o  = und_q;
  assign overrun_o   = ovr_q;

endmodule
